pattern_port: RTL and testbench

//   Parametrised pattern output port: drives a WIDTH-bit bus (e.g. board LEDs)

---
 rtl/pattern_port.sv | 121 ++++++++++++
 tb/tb_pattern_port.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_port.sv
// rtl/pattern_port.sv - registered pattern output port stepping through a constant table
// Modes: fixed, cyclic, ping-pong and one-shot, paced by an internal prescaler.
module pattern_port #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter logic [WIDTH*DEPTH-1:0] PATTERN = 16'h0F5A,
   parameter int DIV = 12000000,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             start,
   output logic [WIDTH-1:0] data,
   output logic [IW-1:0]    idx,
   output logic             tick,
   output logic             done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   localparam logic [1:0] M_FIXED    = 2'b00;
   localparam logic [1:0] M_CYCLE    = 2'b01;
   localparam logic [1:0] M_PINGPONG = 2'b10;
   localparam logic [1:0] M_ONESHOT  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} os_state_t;

   os_state_t       os_state;
   logic [CW-1:0]   cnt;
   logic            dir_down;
   logic            step;
   logic [IW-1:0]   nxt_idx;
   logic            nxt_dir_down;
   logic            os_finish;

   function automatic logic [WIDTH-1:0] entry(input logic [IW-1:0] i);
      return PATTERN[int'(i)*WIDTH +: WIDTH];
   endfunction

   assign step = en && (cnt == CNT_MAX);

   // Index the table moves to if a step happens this cycle.
   always_comb begin
      nxt_idx      = idx;
      nxt_dir_down = dir_down;
      os_finish    = 1'b0;
      case (mode)
         M_FIXED: nxt_idx = '0;
         M_CYCLE: nxt_idx = (idx == LAST) ? '0 : idx + 1'b1;
         M_PINGPONG: begin
            if (DEPTH == 1) begin
               nxt_idx = '0;
            end else if (!dir_down) begin
               if (idx < LAST) begin
                  nxt_idx = idx + 1'b1;
               end else begin
                  nxt_idx      = idx - 1'b1;
                  nxt_dir_down = 1'b1;
               end
            end else begin
               if (idx > '0) begin
                  nxt_idx = idx - 1'b1;
               end else begin
                  nxt_idx      = idx + 1'b1;
                  nxt_dir_down = 1'b0;
               end
            end
         end
         default: begin
            if (os_state == S_RUN) begin
               if (idx < LAST) nxt_idx = idx + 1'b1;
               else            os_finish = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         idx      <= '0;
         data     <= entry('0);
         dir_down <= 1'b0;
         tick     <= 1'b0;
         done     <= 1'b0;
         os_state <= S_IDLE;
      end else begin
         tick <= 1'b0;
         if (mode != M_PINGPONG) dir_down <= 1'b0;
         if (mode != M_ONESHOT) begin
            done     <= 1'b0;
            os_state <= S_IDLE;
         end
         // A start pulse beats a coincident step: restart from entry 0, no tick.
         if (mode == M_ONESHOT && start) begin
            cnt      <= '0;
            idx      <= '0;
            data     <= entry('0);
            done     <= 1'b0;
            os_state <= S_RUN;
         end else if (step) begin
            cnt  <= '0;
            tick <= 1'b1;
            idx  <= nxt_idx;
            data <= entry(nxt_idx);
            if (mode == M_PINGPONG) dir_down <= nxt_dir_down;
            if (os_finish) begin
               done     <= 1'b1;
               os_state <= S_DONE;
            end
         end else if (en) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pattern_port.sv
// tb/tb_pattern_port.sv - directed self-checking bench for pattern_port
module tb_pattern_port;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       start;
   logic [3:0] data;
   logic [1:0] idx;
   logic       tick;
   logic       done;

   int checks = 0;
   int errors = 0;

   pattern_port #(.WIDTH(4), .DEPTH(4), .PATTERN(16'h0F5A), .DIV(3)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
      .data(data), .idx(idx), .tick(tick), .done(done)
   );

   always #5 clk = ~clk;

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_into(input logic [1:0] m, input logic e);
      mode = m; en = e; start = 1'b0; rst = 1'b1;
      edge1();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mode = 2'b00; start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (c == 2) rst = 1'b0;
         edge1();
         checks++;
         if (data !== 4'hA || idx !== 2'd0 || tick !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset c=%0d: got data=%h idx=%0d tick=%b done=%b, expected data=a idx=0 tick=0 done=0",
                     c, data, idx, tick, done);
         end
      end
   endtask

   task automatic test_cycle();
      logic [3:0] exp_d [12] = '{4'hA, 4'hA, 4'h5, 4'h5, 4'h5, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hA};
      logic       exp_t [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
      reset_into(2'b01, 1'b1);
      for (int k = 0; k < 12; k++) begin
         edge1();
         checks++;
         if (data !== exp_d[k] || tick !== exp_t[k]) begin
            errors++;
            $display("FAIL cycle k=%0d: got data=%h tick=%b, expected data=%h tick=%b",
                     k, data, tick, exp_d[k], exp_t[k]);
         end
      end
   endtask

   task automatic test_pingpong();
      logic [1:0] exp_i [8] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
      logic [3:0] exp_d [8] = '{4'h5, 4'hF, 4'h0, 4'hF, 4'h5, 4'hA, 4'h5, 4'hF};
      reset_into(2'b10, 1'b1);
      for (int s = 0; s < 8; s++) begin
         edge1();
         checks++;
         if (tick !== 1'b0) begin
            errors++;
            $display("FAIL pingpong_notick s=%0d: got tick=%b, expected 0", s, tick);
         end
         edge1();
         edge1();
         checks++;
         if (idx !== exp_i[s] || data !== exp_d[s] || tick !== 1'b1) begin
            errors++;
            $display("FAIL pingpong s=%0d: got idx=%0d data=%h tick=%b, expected idx=%0d data=%h tick=1",
                     s, idx, data, tick, exp_i[s], exp_d[s]);
         end
      end
   endtask

   task automatic test_oneshot();
      logic [1:0] exp_i [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
      logic [3:0] exp_d [4] = '{4'h5, 4'hF, 4'h0, 4'h0};
      logic       exp_n [4] = '{0, 0, 0, 1};
      reset_into(2'b11, 1'b1);
      for (int k = 0; k < 4; k++) begin
         edge1();
         checks++;
         if (idx !== 2'd0 || data !== 4'hA || tick !== (k == 2)) begin
            errors++;
            $display("FAIL oneshot_idle k=%0d: got idx=%0d data=%h tick=%b, expected idx=0 data=a tick=%b",
                     k, idx, data, tick, (k == 2));
         end
      end
      start = 1'b1; edge1(); start = 1'b0;
      checks++;
      if (idx !== 2'd0 || data !== 4'hA || done !== 1'b0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_start: got idx=%0d data=%h done=%b tick=%b, expected 0 a 0 0",
                  idx, data, done, tick);
      end
      for (int s = 0; s < 4; s++) begin
         edge1(); edge1(); edge1();
         checks++;
         if (idx !== exp_i[s] || data !== exp_d[s] || done !== exp_n[s] || tick !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_run s=%0d: got idx=%0d data=%h done=%b tick=%b, expected idx=%0d data=%h done=%b tick=1",
                     s, idx, data, done, tick, exp_i[s], exp_d[s], exp_n[s]);
         end
      end
      edge1(); edge1(); edge1();
      checks++;
      if (idx !== 2'd3 || data !== 4'h0 || done !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_hold: got idx=%0d data=%h done=%b, expected 3 0 1", idx, data, done);
      end
      start = 1'b1; edge1(); start = 1'b0;
      checks++;
      if (idx !== 2'd0 || data !== 4'hA || done !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_restart: got idx=%0d data=%h done=%b, expected 0 a 0", idx, data, done);
      end
      edge1(); edge1();
      start = 1'b1; edge1(); start = 1'b0;
      checks++;
      if (idx !== 2'd0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_start_on_step: got idx=%0d tick=%b, expected idx=0 tick=0", idx, tick);
      end
      edge1(); edge1(); edge1();
      checks++;
      if (idx !== 2'd1 || tick !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_cnt_cleared: got idx=%0d tick=%b, expected idx=1 tick=1", idx, tick);
      end
      for (int k = 0; k < 9; k++) edge1();
      checks++;
      if (done !== 1'b1 || idx !== 2'd3) begin
         errors++;
         $display("FAIL oneshot_done2: got done=%b idx=%0d, expected done=1 idx=3", done, idx);
      end
      mode = 2'b01; edge1();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_mode_clear: got done=%b, expected 0", done);
      end
   endtask

   task automatic test_enable_freeze();
      reset_into(2'b01, 1'b1);
      for (int k = 0; k < 4; k++) edge1();
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         edge1();
         checks++;
         if (idx !== 2'd1 || data !== 4'h5 || tick !== 1'b0) begin
            errors++;
            $display("FAIL freeze k=%0d: got idx=%0d data=%h tick=%b, expected 1 5 0", k, idx, data, tick);
         end
      end
      en = 1'b1; edge1();
      checks++;
      if (idx !== 2'd1 || tick !== 1'b0) begin
         errors++;
         $display("FAIL resume1: got idx=%0d tick=%b, expected idx=1 tick=0", idx, tick);
      end
      edge1();
      checks++;
      if (idx !== 2'd2 || data !== 4'hF || tick !== 1'b1) begin
         errors++;
         $display("FAIL resume2: got idx=%0d data=%h tick=%b, expected 2 f 1", idx, data, tick);
      end
   endtask

   task automatic test_reset_midrun();
      reset_into(2'b11, 1'b1);
      start = 1'b1; edge1(); start = 1'b0;
      for (int k = 0; k < 6; k++) edge1();
      checks++;
      if (idx !== 2'd2 || data !== 4'hF) begin
         errors++;
         $display("FAIL midrun_pre: got idx=%0d data=%h, expected 2 f", idx, data);
      end
      rst = 1'b1; edge1(); rst = 1'b0;
      checks++;
      if (idx !== 2'd0 || data !== 4'hA || done !== 1'b0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL midrun_rst: got idx=%0d data=%h done=%b tick=%b, expected 0 a 0 0", idx, data, done, tick);
      end
      edge1(); edge1(); edge1();
      checks++;
      if (idx !== 2'd0 || tick !== 1'b1) begin
         errors++;
         $display("FAIL midrun_idle: got idx=%0d tick=%b, expected idx=0 tick=1", idx, tick);
      end
      mode = 2'b00;
      for (int e = 0; e < 9; e++) begin
         edge1();
         checks++;
         if (data !== 4'hA || idx !== 2'd0 || tick !== (e % 3 == 2)) begin
            errors++;
            $display("FAIL fixed e=%0d: got data=%h idx=%0d tick=%b, expected data=a idx=0 tick=%b",
                     e, data, idx, tick, (e % 3 == 2));
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 2'b00; start = 1'b0;
      test_reset();
      test_cycle();
      test_pingpong();
      test_oneshot();
      test_enable_freeze();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
